// File: rtl/testbus_capture_if.sv
// Readout stream of the testbus capture buffer: valid/ready words, oldest first.
interface testbus_capture_if #(parameter int WIDTH = 16);
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_last;

    modport master (output rd_valid, rd_data, rd_last, input rd_ready);
    modport slave  (input rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/testbus_capture.sv
// Triggered testbus logic analyser: circular pre-trigger buffer, programmable
// post-trigger depth, then a valid/ready readout of the captured window.
module testbus_capture #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic [WIDTH-1:0]           testbus,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [WIDTH-1:0]           trig_mask,
    input  logic [WIDTH-1:0]           trig_value,
    input  logic [$clog2(DEPTH)-1:0]   post_count,
    output logic [$clog2(DEPTH)-1:0]   trig_pos,
    output logic                       busy,
    testbus_capture_if.master          rd
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, post_cnt, post_len, wr_inc, post_sel;
    logic [AW:0]      fill, fill_inc, rd_cnt;
    logic             hit, trig, we, xfer, done_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm) state_nxt = ARMED;
            ARMED:   if (trig) state_nxt = (post_count != '0) ? POST : DONE;
            POST:    if (we && post_cnt == AW'(1)) state_nxt = DONE;
            DONE:    if (xfer && rd_cnt == (AW+1)'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        hit         = ((testbus ^ trig_value) & trig_mask) == '0;
        trig        = (state == ARMED) && clk_en && hit;
        we          = ((state == ARMED) || (state == POST)) && clk_en && !abort;
        busy        = (state != IDLE);
        rd.rd_valid = (state == DONE) && (rd_cnt != '0);
        rd.rd_last  = rd.rd_valid && (rd_cnt == (AW+1)'(1));
        rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : '0;
        xfer        = rd.rd_valid && rd.rd_ready;
        done_entry  = (state != DONE) && (state_nxt == DONE);
        wr_inc      = wr_ptr + AW'(1);
        fill_inc    = (fill == (AW+1)'(DEPTH)) ? fill : fill + (AW+1)'(1);
        // Direct ARMED->DONE only happens with post_count zero.
        post_sel    = (state == POST) ? post_len : '0;
    end

    // Sample storage carries no reset; only the control state below does.
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= testbus;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
            post_len <= '0;
            rd_ptr   <= '0;
            rd_cnt   <= '0;
            trig_pos <= '0;
        end else begin
            if (state == IDLE && arm && !abort) begin
                wr_ptr <= '0;
                fill   <= '0;
            end else if (we) begin
                wr_ptr <= wr_inc;
                fill   <= fill_inc;
            end

            if (trig && !abort) begin
                post_cnt <= post_count;
                post_len <= post_count;
            end else if (we && state == POST) begin
                post_cnt <= post_cnt - AW'(1);
            end

            // Entry into DONE is always a write cycle, so the *_inc values
            // describe the buffer as it stands once capture has finished.
            if (done_entry) begin
                rd_ptr   <= wr_inc - fill_inc[AW-1:0];
                trig_pos <= fill_inc[AW-1:0] - AW'(1) - post_sel;
                rd_cnt   <= fill_inc;
            end else if (xfer) begin
                rd_ptr <= rd_ptr + AW'(1);
                rd_cnt <= rd_cnt - (AW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_testbus_capture.sv
// Randomised scoreboard bench for testbus_capture: the expected readout window
// is derived from the sample list, trigger rule and post count.
module tb_testbus_capture;
    localparam int DEPTH = 16;
    localparam int W     = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  testbus = '0;
    logic [W-1:0]  trig_mask = '0;
    logic [W-1:0]  trig_value = '0;
    logic [AW-1:0] post_count = '0;
    logic [AW-1:0] trig_pos;
    logic          busy;

    testbus_capture_if #(.WIDTH(W)) bus ();

    testbus_capture #(.DEPTH(DEPTH), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .testbus(testbus),
        .arm(arm), .abort(abort), .trig_mask(trig_mask), .trig_value(trig_value),
        .post_count(post_count), .trig_pos(trig_pos), .busy(busy), .rd(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic          last;
        logic [AW-1:0] tpos;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] smp[$];
    int           total = 0;
    int           bad = 0;
    int           xfers = 0;
    int           stall_req = 0;
    bit           rdy_all = 1'b1;
    exp_t         me;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Consumer: random or always-ready, with an optional 5-cycle stall mid-readout.
    initial begin : rdy_drv
        int seen;
        int cnt;
        seen = 0;
        cnt = 0;
        bus.rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req != seen && bus.rd_valid && sb.size() <= 10) begin
                seen = stall_req;
                cnt = 5;
            end
            if (cnt > 0) begin
                bus.rd_ready = 1'b0;
                cnt--;
            end else begin
                bus.rd_ready = rdy_all ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Every presented word must equal the scoreboard head, so a stall that
    // changes rd_data is caught as well as a wrong transfer.
    always @(negedge clk) begin
        if (rst_n && bus.rd_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                me = sb[0];
                chk("rd_data", bus.rd_data, me.data);
                chk("rd_last", bus.rd_last, me.last);
                chk("trig_pos", trig_pos, me.tpos);
                if (bus.rd_ready) begin
                    void'(sb.pop_front());
                    xfers++;
                end
            end
        end
    end

    task automatic cyc(input logic en, input logic [W-1:0] d, input logic a, input logic ab);
        clk_en = en;
        testbus = d;
        arm = a;
        abort = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 3000 && sb.size() != 0; c++)
            cyc(1'($urandom_range(0, 1)), W'($urandom), 1'b0, 1'b0);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end else begin
            chk("busy_after_last", busy, 0);
            chk("valid_after_last", bus.rd_valid, 0);
        end
    endtask

    // Reference: the window is the last min(n, DEPTH) of the n samples up to
    // and including the post-trigger ones; trigger index within it is keep-1-post.
    task automatic do_capture(input logic [W-1:0] mask, input logic [W-1:0] val,
                              input int post, input int en_pct, input bit drain);
        int t;
        int n;
        int keep;
        int i;
        exp_t e;
        t = -1;
        trig_mask = mask;
        trig_value = val;
        post_count = AW'(post);
        foreach (smp[k]) if (t < 0 && ((smp[k] & mask) == (val & mask))) t = k;
        if (t < 0) begin
            smp.push_back(val);
            t = smp.size() - 1;
        end
        n = t + post + 1;
        while (smp.size() < n) smp.push_back(W'($urandom));
        keep = (n < DEPTH) ? n : DEPTH;
        for (int k = 0; k < keep; k++) begin
            e.data = smp[n - keep + k];
            e.last = (k == keep - 1);
            e.tpos = AW'(keep - 1 - post);
            sb.push_back(e);
        end
        cyc(1'b1, W'($urandom), 1'b1, 1'b0);
        i = 0;
        while (i < n) begin
            if ($urandom_range(1, 100) <= en_pct) begin
                cyc(1'b1, smp[i], 1'b0, 1'b0);
                i++;
            end else begin
                cyc(1'b0, W'($urandom), 1'b0, 1'b0);
            end
        end
        if (drain) wait_drain();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_last", bus.rd_last, 0);
        chk("rst_trig_pos", trig_pos, 0);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Basic: 0..40, trigger on 0x14, three post samples.
        smp.delete();
        for (int k = 0; k <= 40; k++) smp.push_back(W'(k));
        rdy_all = 1'b1;
        do_capture(16'hFFFF, 16'h0014, 3, 100, 1'b1);

        // Short pre-trigger window.
        smp.delete();
        for (int k = 0; k < 6; k++) smp.push_back(W'(k));
        do_capture(16'hFFFF, 16'h0002, 0, 100, 1'b1);

        // clk_en gaps plus a mid-readout stall with a random consumer.
        smp.delete();
        for (int k = 0; k < 24; k++) smp.push_back(W'($urandom) & 16'h7FFF);
        smp.push_back(16'hBEEF);
        rdy_all = 1'b0;
        stall_req++;
        do_capture(16'hFFFF, 16'hBEEF, 5, 50, 1'b1);

        // Masked compare: only 0xFF5F matches.
        smp.delete();
        smp.push_back(16'h1234);
        smp.push_back(16'hFF5F);
        do_capture(16'h00F0, 16'h0A50, 1, 100, 1'b1);

        // Empty mask fires on the first sample.
        smp.delete();
        for (int k = 0; k < 5; k++) smp.push_back(W'($urandom));
        do_capture(16'h0000, W'($urandom), 2, 70, 1'b1);

        // Abort and arm together in POST: abort wins, next capture starts empty.
        rdy_all = 1'b1;
        trig_mask = 16'hFFFF;
        trig_value = 16'hABCD;
        post_count = AW'(10);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        cyc(1'b1, 16'h0001, 1'b0, 1'b0);
        cyc(1'b1, 16'h0002, 1'b0, 1'b0);
        cyc(1'b1, 16'hABCD, 1'b0, 1'b0);
        cyc(1'b1, 16'h0003, 1'b0, 1'b0);
        chk("busy_in_post", busy, 1);
        cyc(1'b1, 16'h0004, 1'b1, 1'b1);
        chk("abort_busy", busy, 0);
        chk("abort_valid", bus.rd_valid, 0);
        repeat (3) begin
            cyc(1'b1, 16'hABCD, 1'b0, 1'b0);
            chk("post_abort_idle", busy, 0);
        end
        smp.delete();
        smp.push_back(16'h0011);
        smp.push_back(16'h0022);
        do_capture(16'hFFFF, 16'h0022, 0, 100, 1'b1);

        // Reset after four of sixteen words are read.
        smp.delete();
        for (int k = 0; k < 20; k++) smp.push_back(W'($urandom) & 16'h7FFF);
        smp.push_back(16'hBEEF);
        base = xfers;
        do_capture(16'hFFFF, 16'hBEEF, 4, 100, 1'b0);
        for (int c = 0; c < 500 && xfers < base + 4; c++) cyc(1'b0, '0, 1'b0, 1'b0);
        chk("reset_point_reached", (xfers >= base + 4), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.rd_valid, 0);
        chk("async_rst_last", bus.rd_last, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_data", bus.rd_data, 0);
        chk("async_rst_trig_pos", trig_pos, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        trig_mask = '0;
        repeat (8) begin
            cyc(1'b1, W'($urandom), 1'b0, 1'b0);
            chk("no_arm_idle", busy, 0);
            chk("no_arm_valid", bus.rd_valid, 0);
        end
        smp.delete();
        for (int k = 0; k < 9; k++) smp.push_back(W'($urandom) & 16'h7FFF);
        do_capture(16'hFFFF, 16'hBEEF, 3, 80, 1'b1);

        // Random captures.
        for (int r = 0; r < 6; r++) begin
            int len;
            smp.delete();
            len = $urandom_range(2, 30);
            for (int k = 0; k < len; k++) smp.push_back(W'($urandom));
            rdy_all = 1'($urandom_range(0, 1));
            do_capture(W'($urandom) & 16'h0707, W'($urandom), $urandom_range(0, 15),
                       $urandom_range(30, 100), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
